// File: rtl/seven_seg_pkg.sv
// Shared segment types and glyph constants for the seven_seg display driver.
// Bit order is a..g from bit 6 down to bit 0, with 1 meaning lit.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_ALL   = 7'b1111111;

  localparam seg_t SEG_0 = 7'b1111110;
  localparam seg_t SEG_1 = 7'b0110000;
  localparam seg_t SEG_2 = 7'b1101101;
  localparam seg_t SEG_3 = 7'b1111001;
  localparam seg_t SEG_4 = 7'b0110011;
  localparam seg_t SEG_5 = 7'b1011011;
  localparam seg_t SEG_6 = 7'b1011111;
  localparam seg_t SEG_7 = 7'b1110000;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1110011;

  localparam seg_t SEG_A = 7'b1110111;
  localparam seg_t SEG_B = 7'b0011111;
  localparam seg_t SEG_C = 7'b1001110;
  localparam seg_t SEG_D = 7'b0111101;
  localparam seg_t SEG_E = 7'b1001111;
  localparam seg_t SEG_F = 7'b1000111;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 4-bit code to segment pattern lookup.
// Codes 10-15 show hex glyphs only when SEVEN_SEG_HEX_EN is defined, else blank.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
`ifdef SEVEN_SEG_HEX_EN
      4'd10:   o_seg = SEG_A;
      4'd11:   o_seg = SEG_B;
      4'd12:   o_seg = SEG_C;
      4'd13:   o_seg = SEG_D;
      4'd14:   o_seg = SEG_E;
      4'd15:   o_seg = SEG_F;
`endif
      // Unknown or unsupported codes fall back to blank so no X reaches the pads.
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg.sv
// Registered seven-segment driver: priority override, polarity, output flop.
// Optional hex glyphs for codes 10-15 are enabled by the SEVEN_SEG_HEX_EN macro.
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] segments
);

  localparam seg_t RESET_VAL = ACTIVE_LOW ? SEG_ALL : SEG_BLANK;

  logic [6:0] w_decoded;
  logic [6:0] w_selected;
  logic [6:0] w_polar;
  logic [6:0] r_segments;

  seven_seg_decode u_decode (
    .i_code (data),
    .o_seg  (w_decoded)
  );

  // lamp_test outranks blank so a lamp check works even on a blanked digit.
  always_comb begin
    w_selected = w_decoded;
    if (lamp_test)  w_selected = SEG_ALL;
    else if (blank) w_selected = SEG_BLANK;
  end

  assign w_polar = ACTIVE_LOW ? ~w_selected : w_selected;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_segments <= RESET_VAL;
    else     r_segments <= w_polar;
  end

  assign segments = r_segments;

endmodule

// File: tb/tb_seven_seg.sv
// Bench for seven_seg: directed literal checks plus randomized traffic against
// a per-segment behavioural model, on active-high and active-low instances.
module tb_seven_seg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] data = 4'd0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [6:0] seg_hi;
  logic [6:0] seg_lo;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] exp_q[$];

  seven_seg #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .blank     (blank),
    .lamp_test (lamp_test),
    .segments  (seg_hi)
  );

  seven_seg #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .blank     (blank),
    .lamp_test (lamp_test),
    .segments  (seg_lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Model: for each segment, the set of codes that light it.
  function automatic bit seg_lit(int s, int d);
    case (s)
      0: return d inside {0, 2, 3, 5, 6, 7, 8, 9, 10, 12, 14, 15};
      1: return d inside {0, 1, 2, 3, 4, 7, 8, 9, 10, 13};
      2: return d inside {0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13};
      3: return d inside {0, 2, 3, 5, 6, 8, 11, 12, 13, 14};
      4: return d inside {0, 2, 6, 8, 10, 11, 12, 13, 14, 15};
      5: return d inside {0, 4, 5, 6, 8, 9, 10, 11, 12, 14, 15};
      default: return d inside {2, 3, 4, 5, 6, 8, 9, 10, 11, 13, 14, 15};
    endcase
  endfunction

  function automatic logic [6:0] model(int d, bit b, bit l);
    logic [6:0] p;
    bit hex_on;
`ifdef SEVEN_SEG_HEX_EN
    hex_on = 1'b1;
`else
    hex_on = 1'b0;
`endif
    if (l) return 7'b1111111;
    if (b) return 7'b0000000;
    if (d > 9 && !hex_on) return 7'b0000000;
    p = '0;
    for (int s = 0; s < 7; s++) p[6-s] = seg_lit(s, d);
    return p;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: each edge outside reset queues the value the register must load
  always @(posedge clk) begin
    if (!rst) exp_q.push_back(model(int'(data), blank, lamp_test));
  end

  always @(negedge clk) begin
    logic [6:0] e;
    if (rst) begin
      exp_q.delete();
      check("sb_reset_hi", seg_hi, 7'b0000000);
      check("sb_reset_lo", seg_lo, 7'b1111111);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_hi", seg_hi, e);
      check("sb_lo", seg_lo, ~e);
    end
  end

  // driver tasks
  task automatic apply(input logic [3:0] d, input logic b, input logic l);
    @(posedge clk);
    #2;
    data = d;
    blank = b;
    lamp_test = l;
  endtask

  task automatic expect_next(input string name, input logic [6:0] exp);
    @(posedge clk);
    #1;
    check(name, seg_hi, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_hi", seg_hi, 7'b0000000);
    check("reset_lo", seg_lo, 7'b1111111);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // digit sweep; the scoreboard covers all ten, literals pin the model
    for (int d = 0; d < 10; d++) apply(4'(d), 1'b0, 1'b0);
    apply(4'd2, 1'b0, 1'b0);
    expect_next("digit2", 7'b1101101);
    apply(4'd9, 1'b0, 1'b0);
    expect_next("digit9", 7'b1110011);
    apply(4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("polarity_lo_0", seg_lo, 7'b0000001);

`ifdef SEVEN_SEG_HEX_EN
    apply(4'd10, 1'b0, 1'b0); expect_next("code10", 7'b1110111);
    apply(4'd12, 1'b0, 1'b0); expect_next("code12", 7'b1001110);
    apply(4'd15, 1'b0, 1'b0); expect_next("code15", 7'b1000111);
`else
    apply(4'd10, 1'b0, 1'b0); expect_next("code10", 7'b0000000);
    apply(4'd12, 1'b0, 1'b0); expect_next("code12", 7'b0000000);
    apply(4'd15, 1'b0, 1'b0); expect_next("code15", 7'b0000000);
`endif

    // priority
    apply(4'd1, 1'b1, 1'b0); expect_next("blank", 7'b0000000);
    apply(4'd1, 1'b1, 1'b1); expect_next("lamp_over_blank", 7'b1111111);
    apply(4'd1, 1'b0, 1'b0); expect_next("release", 7'b0110000);

    // latency: change 3 -> 4 just after an edge
    apply(4'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("lat_load3", seg_hi, 7'b1111001);
    data = 4'd4;
    #2;
    check("lat_hold3", seg_hi, 7'b1111001);
    @(posedge clk); #1;
    check("lat_load4", seg_hi, 7'b0110011);

    // async reset mid-cycle while showing 8
    apply(4'd8, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_reset8", seg_hi, 7'b1111111);
    #1 rst = 1'b1;
    #1;
    check("async_rst_hi", seg_hi, 7'b0000000);
    check("async_rst_lo", seg_lo, 7'b1111111);
    @(posedge clk); #2 rst = 1'b0;
    expect_next("post_reset8", 7'b1111111);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      apply(4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0));
    end
    repeat (2) @(posedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
